// File: rtl/freq_div_ctrl.sv
// -----------------------------------------------------------------------------
// freq_div_ctrl
//
// Run-time controller for a clock-enable style frequency divider. It holds the
// divide ratio, takes new ratios over a valid/ready port, and starts and stops
// the divided output only on period boundaries. A ratio N produces a period of
// N clk cycles: high for floor(N/2) cycles, then low for the rest.
//
// Build option (define to enable):
//   FREQ_DIV_CTRL_GLITCHFREE_EN
//     defined   : a ratio accepted while running is parked in div_nxt and
//                 applied at the next period boundary (PEND state). cfg_ready
//                 is low while a ratio is parked.
//     undefined : no PEND state. cfg_ready is always 1. A legal ratio accepted
//                 while running takes effect at once and restarts the period.
//
// Parameters:
//   CNT_W       - width of the ratio and the period counter
//   DEFAULT_DIV - ratio loaded at reset (legal range 2 .. 2^CNT_W-1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   run request, level sensitive
//   cfg_valid  in   a new ratio is offered
//   cfg_div    in   offered ratio N
//   cfg_ready  out  a ratio can be accepted this cycle (decoded from state)
//   cfg_err    out  one-cycle pulse after an accepted ratio below 2
//   clk_out    out  divided output, registered
//   tick       out  one-cycle pulse with each rising edge of clk_out
//   div_cur    out  ratio currently in effect
//   busy       out  high while dividing
// -----------------------------------------------------------------------------
module freq_div_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
`endif

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
  logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
`endif
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Decoded handshake and period status shared by both combinational blocks.
  logic xfer;       // a ratio is transferred on this edge
  logic legal;      // offered ratio is usable (N >= 2)
  logic take;       // legal ratio transferred on this edge
  logic last;       // counter sits on the final cycle of the period
  logic restart;    // a new period begins on this edge

`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
  assign cfg_ready = (state_q != ST_PEND);
`else
  assign cfg_ready = 1'b1;
`endif

  assign xfer  = cfg_valid && cfg_ready;
  assign legal = (cfg_div > ONE);
  assign take  = xfer && legal;
  // Only meaningful while running; div_cur is always >= 2 so no underflow.
  assign last  = (cnt_q == (div_cur_q - ONE));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Stopping is decided only at the boundary, so dropping en never
        // truncates a period and raising it again before then cancels the stop.
        if (last && !en) begin
          state_d = ST_IDLE;
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
        end else if (take) begin
          state_d = ST_PEND;
`endif
        end
      end
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
      ST_PEND: begin
        if (last) state_d = en ? ST_RUN : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
    div_nxt_d = div_nxt_q;
`endif
    restart   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A ratio offered together with en governs the very first period.
        if (take) div_cur_d = cfg_div;
        cnt_d   = '0;
        restart = en;
      end

      ST_RUN: begin
        if (last && !en) begin
          // Stopping: nothing further to divide, so a ratio accepted on this
          // edge is applied directly instead of being parked.
          cnt_d = '0;
          if (take) div_cur_d = cfg_div;
        end else if (take) begin
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
          // Park the ratio; the running period completes at the old ratio.
          div_nxt_d = cfg_div;
          if (last) begin
            cnt_d   = '0;
            restart = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
`else
          // Apply immediately and start a fresh period at the new ratio.
          div_cur_d = cfg_div;
          cnt_d     = '0;
          restart   = 1'b1;
`endif
        end else if (last) begin
          cnt_d   = '0;
          restart = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
      ST_PEND: begin
        if (last) begin
          // The parked ratio lands on the boundary whether or not we continue.
          div_cur_d = div_nxt_q;
          cnt_d     = '0;
          restart   = en;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`endif

      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output values are derived from the next counter and ratio so that the
  // registered clk_out lines up with the registered cnt in the same cycle.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    clk_out_d = busy_d && (cnt_d < (div_cur_d >> 1));
    tick_d    = restart;
    err_d     = xfer && !legal;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_cur_q <= RESET_DIV;
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
      div_nxt_q <= RESET_DIV;
`endif
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
`ifdef FREQ_DIV_CTRL_GLITCHFREE_EN
      div_nxt_q <= div_nxt_d;
`endif
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign cfg_err = err_q;
  assign div_cur = div_cur_q;
  assign busy    = busy_q;

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Run-time controller for the clock-enable style frequency divider. It owns the divide ratio, accepts new ratios from a valid/ready configuration port, starts and stops the divided output on period boundaries, and applies ratio changes without runt pulses. It sits between the system-control register logic and the divider output, on the same `clk` domain.

## Interface
- `CNT_W`, 16: width of the divide ratio and the period counter.
- `DEFAULT_DIV`, 10: ratio loaded at reset. Legal range is 2 to 2^CNT_W-1.

- `clk` input 1: single system clock. All logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: run request. Level sensitive.
- `cfg_valid` input 1: a new ratio is offered.
- `cfg_div` input CNT_W: offered ratio N.
- `cfg_ready` output 1: the controller can accept a ratio this cycle.
- `cfg_err` output 1: one-cycle pulse when an accepted ratio is illegal (N<2).
- `clk_out` output 1: divided output. Registered.
- `tick` output 1: one-cycle pulse coincident with each rising edge of `clk_out`.
- `div_cur` output CNT_W: ratio currently in effect.
- `busy` output 1: 1 in RUN or PEND.

## Operation
- **States**
  - IDLE: `clk_out`=0, counter `cnt`=0.
  - RUN: dividing.
  - PEND: dividing, with one accepted ratio held in `div_nxt`.
- **Waveform for ratio N**
  - `cnt` runs 0..N-1.
  - `clk_out`=1 while `cnt` < N>>1, else 0. High time is floor(N/2) cycles, low time is N-floor(N/2) cycles.
  - Example: N=10 gives 5 high/5 low. N=3 gives 1 high/2 low.
- **Boundary**: the edge at which `cnt`==N-1 in RUN or PEND.
- **Configuration handshake**
  - A transfer occurs on a rising edge where `cfg_valid`&&`cfg_ready`.
  - `cfg_ready`=1 in IDLE and RUN, 0 in PEND.
  - An illegal N (0 or 1) is still accepted. It pulses `cfg_err` on the next cycle, leaves the ratio unchanged, and causes no state change.
- **Transitions**
  - IDLE, legal transfer: `div_cur`<=N on the same edge.
  - IDLE with `en`=1: go to RUN. Set `cnt`<=0, `clk_out`<=1, `tick`<=1.
  - If IDLE sees `en` and a transfer on the same edge, the new ratio governs the first period.
  - RUN, legal transfer: go to PEND with `div_nxt`<=N. The current period completes at the old ratio.
  - PEND at boundary: `div_cur`<=`div_nxt`, `cnt`<=0, go to RUN (or IDLE if `en`=0).
  - RUN/PEND at boundary with `en`=0: go to IDLE, `clk_out` stays 0. Deasserting `en` never truncates a period.
  - RUN/PEND at boundary with `en`=1: `cnt`<=0, `clk_out`<=1, `tick`<=1.
  - A transfer accepted on the boundary edge itself goes to PEND and takes effect at the following boundary.
  - `en` re-asserted before the boundary cancels the stop; no gap is produced.
- **Reset** (asynchronous, including mid-period)
  - Outputs: `clk_out`=0, `tick`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=1.
  - Internal: state IDLE, `cnt`=0, `div_cur`=`DEFAULT_DIV`, and any pending ratio is discarded.

## Timing
- Latency from `en` sampled high in IDLE to `clk_out`=1 is 1 edge.
- The period is exactly `div_cur` cycles.
- `tick` is high for the first cycle of each high phase.
- `cfg_err` asserts on the cycle after the transfer edge, for one cycle.
- `div_cur` updates on the transfer edge (IDLE) or on the boundary edge (PEND).
- All outputs are registered except `cfg_ready`, which is decoded from state.

## Configuration
- `FREQ_DIV_CTRL_GLITCHFREE_EN`
  - Defined: behaviour as above. Ratio changes are deferred to the period boundary through PEND.
  - Undefined: PEND is not built and `cfg_ready` is constantly 1 outside reset. A legal transfer in RUN sets `div_cur`<=N, `cnt`<=0, `clk_out`<=1, `tick`<=1 on the transfer edge, so the current period is truncated.
  - `en` stop behaviour is identical in both builds.

## Test plan
- **Reset defaults**: reset, then `en`=1 → `clk_out` period 10 cycles (5 high/5 low), `tick` every 10 cycles, `div_cur`=10.
- **Mid-period ratio change**: in RUN at `cnt`=3, transfer N=4 → `cfg_ready` drops; old period finishes (7 more cycles); then periods of 4 (2 high/2 low); `cfg_ready` returns at that boundary. Without the macro, a 4-cycle period starts immediately.
- **Illegal ratio**: transfer N=1 in IDLE → `cfg_err` one pulse, `div_cur` stays 10. Transfer N=0 in RUN → same, and state stays RUN.
- **Odd ratio and minimum**: N=3 gives 1 high/2 low. N=2 gives 1 high/1 low. `tick` aligns with each rise.
- **Stop**: `en`=0 at `cnt`=2 → output continues to the boundary, then IDLE, `busy`=0, `clk_out`=0. A PEND ratio plus `en`=0 at the boundary → `div_cur` updated and IDLE.
- **Reset mid-operation**: assert `rst` asynchronously while `clk_out`=1 in PEND → `clk_out`=0 immediately, `div_cur`=10, pending ratio lost, `cfg_ready`=1.
